// File: rtl/motor_pkg.sv
// Shared motor-drive constants, FSM state encoding and the saturating duty-step helper.
// Pure declarations: no latency, no flow control.
package motor_pkg;

    localparam int PWM_W            = 12;
    localparam int DEF_PERIOD       = 2777;
    localparam int DEF_STEP         = 28;
    localparam int DEF_MAX_DUTY     = 2360;
    localparam int DEF_UPDATE_DIV   = 1;
    localparam int DEF_DEAD_PERIODS = 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RAMP     = 2'd1;
    localparam logic [1:0] ST_REV_DOWN = 2'd2;
    localparam logic [1:0] ST_DEAD     = 2'd3;

    // Move cur toward tgt by at most step; the extra bit keeps add/subtract from wrapping.
    function automatic logic [PWM_W-1:0] step_toward(
        input logic [PWM_W-1:0] cur,
        input logic [PWM_W-1:0] tgt,
        input logic [PWM_W:0]   step
    );
        logic [PWM_W:0] c;
        logic [PWM_W:0] t;
        logic [PWM_W:0] s;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (c < t) begin
            s = c + step;
            if (s > t) s = t;
        end else if (c > t) begin
            s = (c > step) ? (c - step) : '0;
            if (s < t) s = t;
        end else begin
            s = c;
        end
        return s[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// PWM period counter: tick_o on each wrap, upd_o on every UPDATE_DIV-th tick.
// Both outputs are combinational decodes of registered counters; free-running, no backpressure.
module pwm_period_tick
    import motor_pkg::*;
#(
    parameter int PERIOD     = DEF_PERIOD,
    parameter int UPDATE_DIV = DEF_UPDATE_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic upd_o
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DIV_W = $clog2(UPDATE_DIV + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    assign tick_o = (cnt_q == CNT_W'(PERIOD - 1));
    assign upd_o  = tick_o && (div_q == DIV_W'(UPDATE_DIV - 1));

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        div_d = div_q;
        if (tick_o) begin
            div_d = upd_o ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Slew-limited PWM duty/direction controller with a zero-duty dead time before any direction flip.
// Outputs move only on update pulses; cmd_ready drops while a reversal is draining or dead-timing.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int PERIOD       = DEF_PERIOD,
    parameter int STEP         = DEF_STEP,
    parameter int UPDATE_DIV   = DEF_UPDATE_DIV,
    parameter int DEAD_PERIODS = DEF_DEAD_PERIODS,
    parameter int MAX_DUTY     = DEF_MAX_DUTY
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_enable,
    input  logic             cmd_dir,
    input  logic [PWM_W-1:0] cmd_duty,
    output logic [PWM_W-1:0] period,
    output logic [PWM_W-1:0] duty_period,
    output logic             direction,
    output logic             enable,
    output logic             at_target
);

    localparam int               DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS + 1) : 1;
    localparam logic [PWM_W:0]   STEP_V = (PWM_W + 1)'(STEP);
    localparam logic [PWM_W-1:0] MAX_V  = PWM_W'(MAX_DUTY);

    logic             tick, upd, step_en, accept;
    logic [PWM_W-1:0] cmd_tgt;
    logic [DEAD_W:0]  dead_inc;

    logic [1:0]        state_q, state_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic              dir_q, dir_d;
    logic              en_q, en_d;
    logic [PWM_W-1:0]  tgt_duty_q, tgt_duty_d;
    logic              tgt_dir_q, tgt_dir_d;
    logic              tgt_en_q, tgt_en_d;
    logic [DEAD_W-1:0] dead_q, dead_d;

    pwm_period_tick #(
        .PERIOD     (PERIOD),
        .UPDATE_DIV (UPDATE_DIV)
    ) u_tick (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .tick_o (tick),
        .upd_o  (upd)
    );

    // upd is always a subset of tick; gating on both keeps updates pinned to a period boundary.
    assign step_en   = upd && tick;
    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RAMP);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_tgt   = !cmd_enable ? '0 : ((cmd_duty > MAX_V) ? MAX_V : cmd_duty);
    assign dead_inc  = {1'b0, dead_q} + 1'b1;

    assign period      = PWM_W'(PERIOD);
    assign duty_period = duty_q;
    assign direction   = dir_q;
    assign enable      = en_q;
    assign at_target   = (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        en_d       = en_q;
        tgt_duty_d = tgt_duty_q;
        tgt_dir_d  = tgt_dir_q;
        tgt_en_d   = tgt_en_q;
        dead_d     = dead_q;

        // The step always uses the target held before this cycle's command.
        if (step_en) begin
            if (tgt_en_q) en_d = 1'b1;
            case (state_q)
                ST_RAMP: begin
                    duty_d = step_toward(duty_q, tgt_duty_q, STEP_V);
                    if (duty_d == tgt_duty_q) state_d = ST_IDLE;
                end
                ST_REV_DOWN: begin
                    duty_d = step_toward(duty_q, '0, STEP_V);
                    if (duty_d == '0) begin
                        state_d = ST_DEAD;
                        dead_d  = '0;
                    end
                end
                ST_DEAD: begin
                    duty_d = '0;
                    if (dead_inc >= (DEAD_W + 1)'(DEAD_PERIODS)) begin
                        dir_d   = tgt_dir_q;
                        state_d = ST_RAMP;
                        dead_d  = '0;
                    end else begin
                        dead_d = dead_inc[DEAD_W-1:0];
                    end
                end
                default: ;
            endcase
            if (!tgt_en_q && (duty_d == '0)) en_d = 1'b0;
        end

        if (accept) begin
            tgt_duty_d = cmd_tgt;
            tgt_dir_d  = cmd_dir;
            tgt_en_d   = cmd_enable;
            dead_d     = '0;
            if ((cmd_tgt == duty_q) && (cmd_dir == dir_q) && (cmd_enable == en_q)) begin
                state_d = ST_IDLE;
            end else if (cmd_enable && (cmd_dir != dir_q) && (duty_q != '0)) begin
                state_d = ST_REV_DOWN;
            end else if ((cmd_dir != dir_q) && (duty_q == '0)) begin
                state_d = ST_DEAD;
            end else begin
                state_d = ST_RAMP;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            en_q       <= 1'b0;
            tgt_duty_q <= '0;
            tgt_dir_q  <= 1'b0;
            tgt_en_q   <= 1'b0;
            dead_q     <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            tgt_duty_q <= tgt_duty_d;
            tgt_dir_q  <= tgt_dir_d;
            tgt_en_q   <= tgt_en_d;
            dead_q     <= dead_d;
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: short PWM period so full ramps fit a small cycle budget,
// plus a default-parameter instance held idle to confirm its reset-time outputs.
module tb_motor_ramp_ctrl;

    localparam int P   = 20;
    localparam int U   = 2;
    localparam int UPD = P * U;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_enable, cmd_dir, def_valid;
    logic [11:0] cmd_duty;
    logic        cmd_ready, direction, enable, at_target;
    logic [11:0] period, duty_period;
    logic        d_ready, d_dir, d_en, d_at;
    logic [11:0] d_period, d_duty;

    int edge_n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motor_ramp_ctrl #(
        .PERIOD(P), .STEP(28), .UPDATE_DIV(U), .DEAD_PERIODS(2), .MAX_DUTY(2360)
    ) dut (
        .CLOCK_50(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_enable(cmd_enable), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
        .period(period), .duty_period(duty_period), .direction(direction),
        .enable(enable), .at_target(at_target)
    );

    motor_ramp_ctrl dut_def (
        .CLOCK_50(clk), .reset(rst), .cmd_valid(def_valid), .cmd_ready(d_ready),
        .cmd_enable(cmd_enable), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty),
        .period(d_period), .duty_period(d_duty), .direction(d_dir),
        .enable(d_en), .at_target(d_at)
    );

    // Bench-side edge count since reset; update edges are the multiples of UPD.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input logic dr, input logic en,
                              input logic rdy, input logic at);
        chk({tag, ".duty"}, 32'(duty_period), d);
        chk({tag, ".dir"}, 32'(direction), 32'(dr));
        chk({tag, ".en"}, 32'(enable), 32'(en));
        chk({tag, ".rdy"}, 32'(cmd_ready), 32'(rdy));
        chk({tag, ".at"}, 32'(at_target), 32'(at));
    endtask

    task automatic send(input logic en, input logic dir, input logic [11:0] d);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_enable = en;
        cmd_dir    = dir;
        cmd_duty   = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic next_upd();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((edge_n % UPD) != 0) && (n < 2 * UPD));
    endtask

    initial begin
        int seq[4];
        seq = '{28, 56, 84, 100};
        rst = 1'b1;
        cmd_valid = 1'b0; def_valid = 1'b0;
        cmd_enable = 1'b0; cmd_dir = 1'b0; cmd_duty = '0;
        #1;
        expect_out("in_reset", 0, 0, 0, 1, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_out("rst_rel", 0, 0, 0, 1, 1);
        chk("period", 32'(period), P);
        chk("def_period", 32'(d_period), 2777);
        chk("def_duty", 32'(d_duty), 0);
        chk("def_en", 32'(d_en), 0);
        chk("def_dir", 32'(d_dir), 0);
        chk("def_rdy", 32'(d_ready), 1);
        chk("def_at", 32'(d_at), 1);

        // Ramp up from rest to 280 in ten steps of 28.
        send(1'b1, 1'b0, 12'd280);
        expect_out("acc280", 0, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            next_upd();
            expect_out($sformatf("up280_%0d", i), 28 * i, 0, 1, 1, i == 10);
        end

        // Reversal: drain to 0, two dead updates, flip, ramp to 140.
        send(1'b1, 1'b1, 12'd140);
        expect_out("acc_rev", 280, 0, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            next_upd();
            expect_out($sformatf("revdn_%0d", i), 280 - 28 * i, 0, 1, 0, 0);
        end
        next_upd();
        expect_out("dead1", 0, 0, 1, 0, 0);
        next_upd();
        expect_out("dead2", 0, 1, 1, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            next_upd();
            expect_out($sformatf("up140_%0d", i), 28 * i, 1, 1, 1, i == 5);
        end

        // Disable: duty falls to 0, enable drops on that same update.
        send(1'b0, 1'b1, 12'd140);
        for (int i = 1; i <= 5; i++) begin
            next_upd();
            expect_out($sformatf("off_%0d", i), 140 - 28 * i, 1, i < 5, 1, i == 5);
        end

        // Final step clamps to the target.
        send(1'b1, 1'b1, 12'd100);
        for (int i = 0; i < 4; i++) begin
            next_upd();
            expect_out($sformatf("up100_%0d", i), seq[i], 1, 1, 1, i == 3);
        end

        // Command identical to current state stays in IDLE.
        send(1'b1, 1'b1, 12'd100);
        expect_out("same_acc", 100, 1, 1, 1, 1);
        next_upd();
        expect_out("same_upd", 100, 1, 1, 1, 1);

        // Over-range request clamps to MAX_DUTY.
        send(1'b1, 1'b1, 12'd4000);
        repeat (80) next_upd();
        expect_out("clamp_80", 2340, 1, 1, 1, 0);
        next_upd();
        expect_out("clamp_81", 2360, 1, 1, 1, 1);

        // Command landing on an update edge: that step uses the old target.
        send(1'b1, 1'b1, 12'd0);
        next_upd();
        expect_out("dn_1", 2332, 1, 1, 1, 0);
        while ((edge_n % UPD) != UPD - 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_enable = 1'b1; cmd_dir = 1'b1; cmd_duty = 12'd2360;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        expect_out("coinc", 2304, 1, 1, 1, 0);
        next_upd();
        expect_out("coinc_n1", 2332, 1, 1, 1, 0);
        next_upd();
        expect_out("coinc_n2", 2360, 1, 1, 1, 1);

        // Reset from full duty, then ramp to 168 and reset mid-ramp.
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_out("rst2", 0, 0, 0, 1, 1);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 1'b0, 12'd280);
        for (int i = 1; i <= 6; i++) next_upd();
        expect_out("mid168", 168, 0, 1, 1, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_out("rst_mid", 0, 0, 0, 1, 1);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 1'b0, 12'd56);
        next_upd();
        expect_out("restart_1", 28, 0, 1, 1, 0);
        next_upd();
        expect_out("restart_2", 56, 0, 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
